// File: rtl/fir_coef_ctrl_if.sv
// Coefficient-write handshake between the configuration master and fir_coef_ctrl.
interface fir_coef_ctrl_if #(
    parameter int AW = 2
);
    logic          i_cfg_valid;
    logic          o_cfg_ready;
    logic [AW-1:0] i_cfg_addr;
    logic [15:0]   i_cfg_data;

    modport master (
        output i_cfg_valid,
        output i_cfg_addr,
        output i_cfg_data,
        input  o_cfg_ready
    );

    modport slave (
        input  i_cfg_valid,
        input  i_cfg_addr,
        input  i_cfg_data,
        output o_cfg_ready
    );
endinterface

// File: rtl/fir_coef_ctrl.sv
// Shadow/active FIR coefficient banks with a strobe-aligned swap and an output-valid
// blanking window that covers samples computed with mixed coefficient sets.
module fir_coef_ctrl #(
    parameter int          NTAPS     = 4,
    parameter int          AW        = 2,
    parameter int          FLUSH_CYC = 6,
    parameter logic [15:0] C0        = 16'h001e,
    parameter logic [15:0] C1        = 16'h46b6,
    parameter logic [15:0] C2        = 16'h46b6,
    parameter logic [15:0] C3        = 16'h001e
) (
    input  logic                  clk,
    input  logic                  i_rst,
    fir_coef_ctrl_if.slave        cfg,
    input  logic                  i_commit,
    input  logic                  i_smp_valid,
    output logic [16*NTAPS-1:0]   o_coef,
    output logic                  o_pending,
    output logic                  o_busy,
    output logic                  o_y_valid,
    output logic                  o_cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ARMED = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam int            CW       = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYC - 1);
    localparam logic [AW:0]   NTAPS_W  = (AW + 1)'(NTAPS);

    function automatic logic [15:0] f_reset_coef(input int k);
        logic [15:0] v;
        case (k)
            0:       v = C0;
            1:       v = C1;
            2:       v = C2;
            3:       v = C3;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    logic [15:0]   r_shadow [NTAPS];
    logic [15:0]   r_active [NTAPS];
    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_cnt;
    logic          r_y_valid;
    logic          r_cfg_err;

    logic          w_ready;
    logic          w_pending;
    logic          w_busy;
    logic          w_wr_fire;
    logic          w_addr_ok;
    logic          w_wr_ok;
    logic          w_swap;

    // Status decode straight from the state register.
    always_comb begin
        w_ready   = 1'b0;
        w_pending = 1'b0;
        w_busy    = 1'b0;
        case (r_state)
            S_IDLE:  w_ready = 1'b1;
            S_LOAD: begin
                w_ready   = 1'b1;
                w_pending = 1'b1;
            end
            S_ARMED: begin
                w_pending = 1'b1;
                w_busy    = 1'b1;
            end
            S_FLUSH: w_busy = 1'b1;
            default: begin
                w_ready   = 1'b0;
                w_pending = 1'b0;
                w_busy    = 1'b0;
            end
        endcase
    end

    assign w_wr_fire = cfg.i_cfg_valid & w_ready;
    assign w_addr_ok = ({1'b0, cfg.i_cfg_addr} < NTAPS_W);
    assign w_wr_ok   = w_wr_fire & w_addr_ok;
    assign w_swap    = (r_state == S_ARMED) & i_smp_valid;

    // Next-state logic; commit wins over a same-cycle write since the write still lands.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_LOAD: begin
                if (i_commit) begin
                    w_next_state = S_ARMED;
                end else if (w_wr_ok) begin
                    w_next_state = S_LOAD;
                end else begin
                    w_next_state = r_state;
                end
            end
            S_ARMED: begin
                if (i_smp_valid) begin
                    w_next_state = S_FLUSH;
                end else begin
                    w_next_state = S_ARMED;
                end
            end
            S_FLUSH: begin
                if (r_cnt == {CW{1'b0}}) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_FLUSH;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Flush countdown, loaded on the swap edge.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_cnt <= {CW{1'b0}};
        end else if (w_swap) begin
            r_cnt <= CNT_LOAD;
        end else if ((r_state == S_FLUSH) && (r_cnt != {CW{1'b0}})) begin
            r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Coefficient banks; the shadow survives a swap as the base for the next edit.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NTAPS; k++) begin
            if (i_rst) begin
                r_shadow[k] <= f_reset_coef(k);
                r_active[k] <= f_reset_coef(k);
            end else begin
                if (w_wr_ok && (cfg.i_cfg_addr == AW'(k))) begin
                    r_shadow[k] <= cfg.i_cfg_data;
                end else begin
                    r_shadow[k] <= r_shadow[k];
                end
                if (w_swap) begin
                    r_active[k] <= r_shadow[k];
                end else begin
                    r_active[k] <= r_active[k];
                end
            end
        end
    end

    // Registered flags: output blanking follows the next state, error pulses one cycle.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_y_valid <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_y_valid <= (w_next_state != S_FLUSH);
            r_cfg_err <= w_wr_fire & ~w_addr_ok;
        end
    end

    for (genvar g = 0; g < NTAPS; g++) begin : g_coef
        assign o_coef[16*g +: 16] = r_active[g];
    end

    assign cfg.o_cfg_ready = w_ready;
    assign o_pending       = w_pending;
    assign o_busy          = w_busy;
    assign o_y_valid       = r_y_valid;
    assign o_cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl: a 4-tap instance plus a 3-tap instance for address errors.
module tb_fir_coef_ctrl;

    localparam logic [63:0] DEF4 = 64'h001e_46b6_46b6_001e;
    localparam logic [47:0] DEF3 = 48'h46b6_46b6_001e;

    logic        clk;
    logic        i_rst;
    logic        i_commit;
    logic        i_commit3;
    logic        i_smp_valid;
    logic [63:0] o_coef;
    logic [47:0] o_coef3;
    logic        o_pending, o_busy, o_y_valid, o_cfg_err;
    logic        o_pending3, o_busy3, o_y_valid3, o_cfg_err3;

    int checks   = 0;
    int failures = 0;

    fir_coef_ctrl_if #(.AW(2)) cfg_if  ();
    fir_coef_ctrl_if #(.AW(2)) cfg3_if ();

    fir_coef_ctrl #(.NTAPS(4), .AW(2), .FLUSH_CYC(6)) u_dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .cfg        (cfg_if.slave),
        .i_commit   (i_commit),
        .i_smp_valid(i_smp_valid),
        .o_coef     (o_coef),
        .o_pending  (o_pending),
        .o_busy     (o_busy),
        .o_y_valid  (o_y_valid),
        .o_cfg_err  (o_cfg_err)
    );

    fir_coef_ctrl #(.NTAPS(3), .AW(2), .FLUSH_CYC(6)) u_dut3 (
        .clk        (clk),
        .i_rst      (i_rst),
        .cfg        (cfg3_if.slave),
        .i_commit   (i_commit3),
        .i_smp_valid(i_smp_valid),
        .o_coef     (o_coef3),
        .o_pending  (o_pending3),
        .o_busy     (o_busy3),
        .o_y_valid  (o_y_valid3),
        .o_cfg_err  (o_cfg_err3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        i_rst                = 1'b1;
        i_commit             = 1'b0;
        i_commit3            = 1'b0;
        i_smp_valid          = 1'b0;
        cfg_if.i_cfg_valid   = 1'b0;
        cfg_if.i_cfg_addr    = 2'd0;
        cfg_if.i_cfg_data    = 16'h0000;
        cfg3_if.i_cfg_valid  = 1'b0;
        cfg3_if.i_cfg_addr   = 2'd0;
        cfg3_if.i_cfg_data   = 16'h0000;

        // Reset held for 10 cycles
        tick();
        check("rst_yvalid_first", {63'd0, o_y_valid}, 64'd0);
        repeat (9) tick();
        check("rst_coef", o_coef, DEF4);
        check("rst_ready", {63'd0, cfg_if.o_cfg_ready}, 64'd1);
        check("rst_busy", {63'd0, o_busy}, 64'd0);
        check("rst_pending", {63'd0, o_pending}, 64'd0);
        check("rst_err", {63'd0, o_cfg_err}, 64'd0);
        check("rst_yvalid_held", {63'd0, o_y_valid}, 64'd0);
        check("rst_coef3", {16'd0, o_coef3}, {16'd0, DEF3});
        i_rst = 1'b0;
        tick();
        check("rel_yvalid", {63'd0, o_y_valid}, 64'd1);

        // Two writes, commit, strobe three cycles later
        cfg_if.i_cfg_valid = 1'b1;
        cfg_if.i_cfg_addr  = 2'd1;
        cfg_if.i_cfg_data  = 16'h7fff;
        tick();
        check("wr1_pending", {63'd0, o_pending}, 64'd1);
        cfg_if.i_cfg_addr  = 2'd2;
        cfg_if.i_cfg_data  = 16'h8000;
        tick();
        check("wr2_coef_unchanged", o_coef, DEF4);
        cfg_if.i_cfg_valid = 1'b0;
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
        check("armed_busy", {63'd0, o_busy}, 64'd1);
        check("armed_ready", {63'd0, cfg_if.o_cfg_ready}, 64'd0);
        check("armed_pending", {63'd0, o_pending}, 64'd1);
        tick();
        check("armed_coef1", o_coef, DEF4);
        tick();
        check("armed_coef2", o_coef, DEF4);
        i_smp_valid = 1'b1;
        tick();
        i_smp_valid = 1'b0;
        check("swap1_coef", o_coef, 64'h001e_8000_7fff_001e);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("flush1_yvalid_%0d", i), {63'd0, o_y_valid}, (i < 6) ? 64'd0 : 64'd1);
            tick();
        end
        check("flush1_done_ready", {63'd0, cfg_if.o_cfg_ready}, 64'd1);
        check("flush1_done_busy", {63'd0, o_busy}, 64'd0);
        check("flush1_done_pending", {63'd0, o_pending}, 64'd0);

        // Write stalls while armed/flushing, lands after the flush
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
        cfg_if.i_cfg_valid = 1'b1;
        cfg_if.i_cfg_addr  = 2'd0;
        cfg_if.i_cfg_data  = 16'h1234;
        tick();
        check("stall_ready_armed", {63'd0, cfg_if.o_cfg_ready}, 64'd0);
        i_smp_valid = 1'b1;
        tick();
        i_smp_valid = 1'b0;
        check("stall_swap_yvalid", {63'd0, o_y_valid}, 64'd0);
        check("stall_ready_flush", {63'd0, cfg_if.o_cfg_ready}, 64'd0);
        check("stall_same_coef", o_coef, 64'h001e_8000_7fff_001e);
        repeat (6) tick();
        check("stall_ready_idle", {63'd0, cfg_if.o_cfg_ready}, 64'd1);
        check("stall_pending_idle", {63'd0, o_pending}, 64'd0);
        tick();
        cfg_if.i_cfg_valid = 1'b0;
        check("stall_accept_pending", {63'd0, o_pending}, 64'd1);
        check("stall_tap0_kept", o_coef, 64'h001e_8000_7fff_001e);

        // Strobe on the commit edge must not swap
        i_commit    = 1'b1;
        i_smp_valid = 1'b1;
        tick();
        i_commit    = 1'b0;
        i_smp_valid = 1'b0;
        check("coinc_busy", {63'd0, o_busy}, 64'd1);
        check("coinc_yvalid", {63'd0, o_y_valid}, 64'd1);
        check("coinc_coef", o_coef, 64'h001e_8000_7fff_001e);
        tick();
        check("armed_wait_coef", o_coef, 64'h001e_8000_7fff_001e);
        i_smp_valid = 1'b1;
        tick();
        i_smp_valid = 1'b0;
        check("swap2_coef", o_coef, 64'h001e_8000_7fff_1234);
        repeat (6) tick();
        check("flush2_yvalid", {63'd0, o_y_valid}, 64'd1);

        // Write and commit in the same cycle
        cfg_if.i_cfg_valid = 1'b1;
        cfg_if.i_cfg_addr  = 2'd3;
        cfg_if.i_cfg_data  = 16'h0bad;
        i_commit           = 1'b1;
        tick();
        cfg_if.i_cfg_valid = 1'b0;
        i_commit           = 1'b0;
        check("wrc_busy", {63'd0, o_busy}, 64'd1);
        check("wrc_coef_before", o_coef, 64'h001e_8000_7fff_1234);
        i_smp_valid = 1'b1;
        tick();
        i_smp_valid = 1'b0;
        check("wrc_coef_after", o_coef, 64'h0bad_8000_7fff_1234);
        repeat (6) tick();

        // Out-of-range address on the 3-tap instance
        cfg3_if.i_cfg_valid = 1'b1;
        cfg3_if.i_cfg_addr  = 2'd3;
        cfg3_if.i_cfg_data  = 16'hffff;
        tick();
        cfg3_if.i_cfg_valid = 1'b0;
        check("err3_pulse", {63'd0, o_cfg_err3}, 64'd1);
        check("err3_pending", {63'd0, o_pending3}, 64'd0);
        check("err3_ready", {63'd0, cfg3_if.o_cfg_ready}, 64'd1);
        check("err4_quiet", {63'd0, o_cfg_err}, 64'd0);
        tick();
        check("err3_one_cycle", {63'd0, o_cfg_err3}, 64'd0);
        i_commit3 = 1'b1;
        tick();
        i_commit3 = 1'b0;
        i_smp_valid = 1'b1;
        tick();
        i_smp_valid = 1'b0;
        check("err3_shadow_intact", {16'd0, o_coef3}, {16'd0, DEF3});
        check("err3_flush_yvalid", {63'd0, o_y_valid3}, 64'd0);
        repeat (6) tick();

        // Reset in the middle of a flush
        cfg_if.i_cfg_valid = 1'b1;
        cfg_if.i_cfg_addr  = 2'd0;
        cfg_if.i_cfg_data  = 16'h5555;
        tick();
        cfg_if.i_cfg_valid = 1'b0;
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
        i_smp_valid = 1'b1;
        tick();
        i_smp_valid = 1'b0;
        check("swap3_coef", o_coef, 64'h0bad_8000_7fff_5555);
        repeat (3) tick();
        check("mid_flush_yvalid", {63'd0, o_y_valid}, 64'd0);
        check("mid_flush_busy", {63'd0, o_busy}, 64'd1);
        i_rst = 1'b1;
        tick();
        check("abort_coef", o_coef, DEF4);
        check("abort_yvalid", {63'd0, o_y_valid}, 64'd0);
        check("abort_busy", {63'd0, o_busy}, 64'd0);
        check("abort_ready", {63'd0, cfg_if.o_cfg_ready}, 64'd1);
        check("abort_pending", {63'd0, o_pending}, 64'd0);
        i_rst = 1'b0;
        tick();
        check("abort_rel_yvalid", {63'd0, o_y_valid}, 64'd1);
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
        check("empty_commit_busy", {63'd0, o_busy}, 64'd1);
        check("empty_commit_pending", {63'd0, o_pending}, 64'd1);
        i_smp_valid = 1'b1;
        tick();
        i_smp_valid = 1'b0;
        check("empty_swap_coef", o_coef, DEF4);
        check("empty_swap_yvalid", {63'd0, o_y_valid}, 64'd0);
        repeat (6) tick();
        check("empty_done_yvalid", {63'd0, o_y_valid}, 64'd1);
        check("empty_done_ready", {63'd0, cfg_if.o_cfg_ready}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
